// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling queue: 2-wide compacting enqueue, up to 2-wide
// in-order dequeue, flush, stall back-pressure and sticky overflow flag.
module fetch_queue #(
  parameter int DEPTH      = 8,
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int GHR_BITS   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [1:0]              in_valid,
  input  logic [ADDR_WIDTH-1:0]   in_pc_0,
  input  logic [ADDR_WIDTH-1:0]   in_pc_1,
  input  logic [INST_WIDTH-1:0]   in_inst_0,
  input  logic [INST_WIDTH-1:0]   in_inst_1,
  input  logic                    in_pred_taken_0,
  input  logic                    in_pred_taken_1,
  input  logic [ADDR_WIDTH-1:0]   in_pred_target_0,
  input  logic [ADDR_WIDTH-1:0]   in_pred_target_1,
  input  logic [GHR_BITS-1:0]     in_pred_hist_0,
  input  logic [GHR_BITS-1:0]     in_pred_hist_1,
  input  logic [1:0]              deq_ready,
  output logic [1:0]              out_valid,
  output logic [ADDR_WIDTH-1:0]   out_pc_0,
  output logic [ADDR_WIDTH-1:0]   out_pc_1,
  output logic [INST_WIDTH-1:0]   out_inst_0,
  output logic [INST_WIDTH-1:0]   out_inst_1,
  output logic                    out_pred_taken_0,
  output logic                    out_pred_taken_1,
  output logic [ADDR_WIDTH-1:0]   out_pred_target_0,
  output logic [ADDR_WIDTH-1:0]   out_pred_target_1,
  output logic [GHR_BITS-1:0]     out_pred_hist_0,
  output logic [GHR_BITS-1:0]     out_pred_hist_1,
  output logic                    stall,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] mem_pc     [DEPTH];
  logic [INST_WIDTH-1:0] mem_inst   [DEPTH];
  logic                  mem_taken  [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_target [DEPTH];
  logic [GHR_BITS-1:0]   mem_hist   [DEPTH];

  logic [PW-1:0] head, tail, head1, tail1;
  logic [PW:0]   count_q, free_slots;
  logic [1:0]    n_req, n_enq, n_deq, deq_mask, take;
  logic          fits;

  logic [ADDR_WIDTH-1:0] w0_pc, w0_target;
  logic [INST_WIDTH-1:0] w0_inst;
  logic                  w0_taken;
  logic [GHR_BITS-1:0]   w0_hist;

  assign head1 = head + 1'b1;
  assign tail1 = tail + 1'b1;
  assign count = count_q;

  assign free_slots = DEPTH_C - count_q;
  assign n_req      = {in_valid[0] & in_valid[1], in_valid[0] ^ in_valid[1]};
  assign fits       = {{(PW-1){1'b0}}, n_req} <= free_slots;
  assign n_enq      = fits ? n_req : 2'd0;

  assign out_valid = (count_q >= (PW+1)'(2)) ? 2'b11 :
                     (count_q == (PW+1)'(1)) ? 2'b01 : 2'b00;
  assign stall     = free_slots < (PW+1)'(4);

  // 10 on deq_ready is not a legal thermometer code and accepts nothing
  assign deq_mask = (deq_ready == 2'b10) ? 2'b00 : deq_ready;
  assign take     = out_valid & deq_mask;
  assign n_deq    = {take[0] & take[1], take[0] ^ take[1]};

  // A lone valid slot (either lane) always lands at tail
  always_comb begin
    if (in_valid[0]) begin
      w0_pc = in_pc_0; w0_inst = in_inst_0; w0_taken = in_pred_taken_0;
      w0_target = in_pred_target_0; w0_hist = in_pred_hist_0;
    end else begin
      w0_pc = in_pc_1; w0_inst = in_inst_1; w0_taken = in_pred_taken_1;
      w0_target = in_pred_target_1; w0_hist = in_pred_hist_1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_pc     <= '{default: '0};
      mem_inst   <= '{default: '0};
      mem_taken  <= '{default: '0};
      mem_target <= '{default: '0};
      mem_hist   <= '{default: '0};
    end else if (!flush) begin
      if (n_enq != 2'd0) begin
        mem_pc[tail]     <= w0_pc;
        mem_inst[tail]   <= w0_inst;
        mem_taken[tail]  <= w0_taken;
        mem_target[tail] <= w0_target;
        mem_hist[tail]   <= w0_hist;
      end
      if (n_enq == 2'd2) begin
        mem_pc[tail1]     <= in_pc_1;
        mem_inst[tail1]   <= in_inst_1;
        mem_taken[tail1]  <= in_pred_taken_1;
        mem_target[tail1] <= in_pred_target_1;
        mem_hist[tail1]   <= in_pred_hist_1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= '0;
      count_q      <= '0;
      overflow_err <= 1'b0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head    <= head + PW'(n_deq);
      tail    <= tail + PW'(n_enq);
      count_q <= count_q + (PW+1)'(n_enq) - (PW+1)'(n_deq);
      if (!fits) overflow_err <= 1'b1;
    end
  end

  assign out_pc_0          = mem_pc[head];
  assign out_pc_1          = mem_pc[head1];
  assign out_inst_0        = mem_inst[head];
  assign out_inst_1        = mem_inst[head1];
  assign out_pred_taken_0  = mem_taken[head];
  assign out_pred_taken_1  = mem_taken[head1];
  assign out_pred_target_0 = mem_target[head];
  assign out_pred_target_1 = mem_target[head1];
  assign out_pred_hist_0   = mem_hist[head];
  assign out_pred_hist_1   = mem_hist[head1];

endmodule
